// File: rtl/onehot_dec_pkg.sv
// Shared widths and the reference one-hot decode used by the pipe and its bench.
// Combinational only: no latency, no handshake.
// Backpressure: not applicable.
package onehot_dec_pkg;

    localparam int DEC_CODE_W = 4;
    localparam int DEC_OUT_W  = 10;

    function automatic logic [DEC_OUT_W-1:0] dec_onehot(input logic [DEC_CODE_W-1:0] code);
        logic [DEC_OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < DEC_OUT_W; i++) begin
            if (32'(code) == i) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_dec_errcnt.sv
// Saturating event counter for out-of-range codes; sticks at all-ones, cleared only by rst.
// Latency: count reflects an increment one clk after inc_i.
// Backpressure: none, counts every cycle inc_i is high.
module onehot_dec_errcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder; codes >= OUT_W give oOUT=0 with oERR=1.
// Latency: 1 clk from accept to oVALID; full throughput (accept while draining).
// Backpressure: oREADY = !oVALID | iREADY; output word held stable while stalled.
// Build option ONEHOT_DEC_ERRCNT_EN adds the saturating oERRCNT invalid-code counter.
module onehot_decoder_pipe
    import onehot_dec_pkg::*;
#(
    parameter int CODE_W   = DEC_CODE_W,
    parameter int OUT_W    = DEC_OUT_W
`ifdef ONEHOT_DEC_ERRCNT_EN
    ,
    parameter int ERRCNT_W = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CODE_W-1:0]   iIN,
    input  logic                iVALID,
    output logic                oREADY,
    output logic [OUT_W-1:0]    oOUT,
    output logic                oERR,
    output logic                oVALID,
    input  logic                iREADY
`ifdef ONEHOT_DEC_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] oERRCNT
`endif
);

    logic [OUT_W-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;
    logic [OUT_W-1:0] dec;
    logic             code_bad;
    logic             accept;

    always_comb begin
        dec = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (32'(iIN) == i) dec[i] = 1'b1;
        end
    end

    assign code_bad = (32'(iIN) >= OUT_W);
    assign oREADY   = !vld_q || iREADY;
    assign accept   = iVALID && oREADY;

    // A drain without a new word only drops valid; data keeps its last value.
    always_comb begin
        out_d = out_q;
        err_d = err_q;
        vld_d = vld_q;
        if (accept) begin
            out_d = dec;
            err_d = code_bad;
            vld_d = 1'b1;
        end else if (iREADY) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            err_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
            vld_q <= vld_d;
        end
    end

    assign oOUT   = out_q;
    assign oERR   = err_q;
    assign oVALID = vld_q;

`ifdef ONEHOT_DEC_ERRCNT_EN
    onehot_dec_errcnt #(
        .W(ERRCNT_W)
    ) u_errcnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (accept && code_bad),
        .count_o(oERRCNT)
    );
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed bench for onehot_decoder_pipe with a queue scoreboard on the output handshake.
module tb_onehot_decoder_pipe;
    import onehot_dec_pkg::*;

    logic                  clk;
    logic                  rst;
    logic [DEC_CODE_W-1:0] iIN;
    logic                  iVALID;
    logic                  oREADY;
    logic [DEC_OUT_W-1:0]  oOUT;
    logic                  oERR;
    logic                  oVALID;
    logic                  iREADY;
`ifdef ONEHOT_DEC_ERRCNT_EN
    logic [1:0]            oERRCNT;
`endif

    typedef struct packed {
        logic [DEC_OUT_W-1:0] out;
        logic                 err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n_acc = 0;
    int   n_out = 0;

    onehot_decoder_pipe #(
        .CODE_W  (DEC_CODE_W),
        .OUT_W   (DEC_OUT_W)
`ifdef ONEHOT_DEC_ERRCNT_EN
        ,
        .ERRCNT_W(2)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iIN    (iIN),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .oOUT   (oOUT),
        .oERR   (oERR),
        .oVALID (oVALID),
        .iREADY (iREADY)
`ifdef ONEHOT_DEC_ERRCNT_EN
        ,
        .oERRCNT(oERRCNT)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: pop on output handshake, then push the word being accepted.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (oVALID) check("onehot_max1", 32'($countones(oOUT) <= 1), 32'd1);
            if (oVALID && iREADY) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_word", 32'(oOUT), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_oOUT", 32'(oOUT), 32'(e.out));
                    check("sb_oERR", 32'(oERR), 32'(e.err));
                end
            end
            if (iVALID && oREADY) begin
                n_acc++;
                e.out = dec_onehot(iIN);
                e.err = (32'(iIN) >= DEC_OUT_W);
                sb.push_back(e);
            end
        end
    end

    initial begin
        int a0;
        int o0;
        rst    = 1'b1;
        iIN    = '0;
        iVALID = 1'b0;
        iREADY = 1'b0;
        #12;
        check("rst_oVALID", 32'(oVALID), 32'd0);
        check("rst_oOUT",   32'(oOUT),   32'd0);
        check("rst_oERR",   32'(oERR),   32'd0);
        check("rst_oREADY", 32'(oREADY), 32'd1);
`ifdef ONEHOT_DEC_ERRCNT_EN
        check("rst_oERRCNT", 32'(oERRCNT), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Sweep 0..9 back to back.
        iREADY = 1'b1;
        iVALID = 1'b1;
        a0 = n_acc;
        o0 = n_out;
        for (int i = 0; i < 10; i++) begin
            iIN = 4'(i);
            tick();
        end
        check("sweep_accepts", 32'(n_acc - a0), 32'd10);
        iVALID = 1'b0;
        tick();
        tick();
        check("sweep_outputs", 32'(n_out - o0), 32'd10);

        // Invalid codes.
        iVALID = 1'b1;
        iIN    = 4'hA;
        tick();
`ifdef ONEHOT_DEC_ERRCNT_EN
        check("errcnt_1", 32'(oERRCNT), 32'd1);
`endif
        iIN = 4'hF;
        tick();
`ifdef ONEHOT_DEC_ERRCNT_EN
        check("errcnt_2", 32'(oERRCNT), 32'd2);
`endif
        check("inv_oOUT", 32'(oOUT), 32'd0);
        check("inv_oERR", 32'(oERR), 32'd1);
        iVALID = 1'b0;
        tick();

        // Backpressure: word 3 held while 7 waits.
        iIN    = 4'd3;
        iVALID = 1'b1;
        tick();
        iREADY = 1'b0;
        iIN    = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_oOUT",   32'(oOUT),   32'h008);
            check("stall_oVALID", 32'(oVALID), 32'd1);
            check("stall_oREADY", 32'(oREADY), 32'd0);
            tick();
        end
        iREADY = 1'b1;
        tick();
        iVALID = 1'b0;
        @(negedge clk);
        check("bp_next_word", 32'(oOUT), 32'h080);
        tick();

        // Bubble: single word 9.
        iIN    = 4'd9;
        iVALID = 1'b1;
        tick();
        iVALID = 1'b0;
        @(negedge clk);
        check("bubble_vld_hi", 32'(oVALID), 32'd1);
        check("bubble_oOUT",   32'(oOUT),   32'h200);
        tick();
        @(negedge clk);
        check("bubble_vld_lo", 32'(oVALID), 32'd0);
        check("drain_hold",    32'(oOUT),   32'h200);
        tick();

`ifdef ONEHOT_DEC_ERRCNT_EN
        // Saturation with a 2-bit counter.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        sb.delete();
        tick();
        iIN    = 4'hC;
        iVALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("errcnt_sat", 32'(oERRCNT), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        iVALID = 1'b0;
        tick();
        tick();
`endif

        // Async reset while stalled with a word pending.
        iIN    = 4'd5;
        iVALID = 1'b1;
        iREADY = 1'b0;
        tick();
        iVALID = 1'b0;
        check("pre_rst_oVALID", 32'(oVALID), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_oVALID", 32'(oVALID), 32'd0);
        check("arst_oOUT",   32'(oOUT),   32'd0);
        check("arst_oERR",   32'(oERR),   32'd0);
`ifdef ONEHOT_DEC_ERRCNT_EN
        check("arst_oERRCNT", 32'(oERRCNT), 32'd0);
`endif
        sb.delete();
        @(negedge clk);
        rst    = 1'b0;
        iREADY = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("no_replay", 32'(oVALID), 32'd0);
        check("sb_empty",  32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
